// File: rtl/dmem_mmio.sv
// dmem_mmio: data memory with a memory-mapped UART transmitter.
//
// Address map (word access, ALUResult[1:0] ignored):
//   0x0000_0000 .. RAM_WORDS*4-1 : data RAM, combinational read, clocked write
//   0x1000_0000 TXDATA           : write pushes WriteData[7:0] into the TX FIFO, reads 0
//   0x1000_0004 STATUS           : read {24'b0, count[3:0], ovf, empty, full, fsm_busy}
//                                  write with WriteData[3]=1 clears ovf
//   anything else                : reads 0, writes ignored
//
// Ports:
//   clk        single clock, rising edge
//   reset      asynchronous, active-low reset
//   MemWrite   store strobe from the core
//   ALUResult  byte address from the core
//   WriteData  store data from the core
//   ReadData   load data returned to the core (combinational)
//   uart_tx    serial line, idle high, 8N1, LSB first
//   tx_busy    high while the TX FSM is not IDLE or the FIFO holds bytes
module dmem_mmio #(
  parameter int RAM_WORDS    = 256,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        uart_tx,
  output logic        tx_busy
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [PW-1:0] PTR_LAST   = PW'(FIFO_DEPTH - 1);
  localparam logic [3:0]    COUNT_FULL = 4'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic          ram_hit;
  logic          txdata_hit;
  logic          status_hit;
  logic [AW-1:0] ram_idx;
  logic          unused_addr_lsbs;

  assign ram_hit          = (ALUResult[31:AW+2] == '0);
  assign txdata_hit       = (ALUResult[31:2] == 30'h0400_0000);
  assign status_hit       = (ALUResult[31:2] == 30'h0400_0001);
  assign ram_idx          = ALUResult[AW+1:2];
  assign unused_addr_lsbs = ^ALUResult[1:0];

  // ---------------------------------------------------------------------------
  // Data RAM: no reset, contents survive reset
  // ---------------------------------------------------------------------------
  logic [31:0] mem [RAM_WORDS];

  always_ff @(posedge clk) begin
    if (MemWrite && ram_hit) begin
      mem[ram_idx] <= WriteData;
    end
  end

  // ---------------------------------------------------------------------------
  // TX FIFO
  // Handshake: the core side offers a byte with push_req (a TXDATA store);
  // it is accepted (push) when the FIFO is not full or the FSM pops in the
  // same cycle, otherwise it is dropped and ovf latches. The FSM side takes
  // the head byte with pop, which it only asserts while the FIFO is non-empty.
  // ---------------------------------------------------------------------------
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [3:0]    count_q;
  logic          ovf_q;
  logic          fifo_empty;
  logic          fifo_full;
  logic [7:0]    fifo_head;
  logic          push_req;
  logic          push;
  logic          pop;
  logic          ovf_set;
  logic          ovf_clr;

  assign fifo_empty = (count_q == 4'd0);
  assign fifo_full  = (count_q == COUNT_FULL);
  assign fifo_head  = fifo_mem[rd_ptr_q];
  assign push_req   = MemWrite && txdata_hit;
  assign push       = push_req && (!fifo_full || pop);
  assign ovf_set    = push_req && !push;
  assign ovf_clr    = MemWrite && status_hit && WriteData[3];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= WriteData[7:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= 4'd0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + 4'd1;
        2'b01:   count_q <= count_q - 4'd1;
        default: count_q <= count_q;
      endcase
      // Set has priority over a clear in the same cycle.
      if (ovf_set)      ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // TX FSM
  // ---------------------------------------------------------------------------
  tx_state_t     state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          timer_done;
  logic          fsm_busy;

  assign timer_done = (timer_q == TIMER_LAST);
  assign fsm_busy   = (state_q != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      bit_idx_q <= 3'd0;
      shreg_q   <= 8'd0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        timer_d   = '0;
        bit_idx_d = 3'd0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shreg_d = fifo_head;
          state_d = START;
        end
      end
      START: begin
        if (timer_done) begin
          timer_d   = '0;
          bit_idx_d = 3'd0;
          state_d   = DATA;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      DATA: begin
        if (timer_done) begin
          timer_d = '0;
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = 3'd0;
            state_d   = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      STOP: begin
        if (timer_done) begin
          timer_d = '0;
          // Chain straight into the next start bit so back-to-back frames
          // carry no idle gap.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shreg_d = fifo_head;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  // Line level is decoded from state so reset drives it high immediately.
  always_comb begin
    uart_tx = 1'b1;
    case (state_q)
      START:   uart_tx = 1'b0;
      DATA:    uart_tx = shreg_q[bit_idx_q];
      default: uart_tx = 1'b1;
    endcase
  end

  assign tx_busy = fsm_busy || !fifo_empty;

  // ---------------------------------------------------------------------------
  // Load data mux
  // ---------------------------------------------------------------------------
  always_comb begin
    ReadData = 32'd0;
    if (ram_hit) begin
      ReadData = mem[ram_idx];
    end else if (status_hit) begin
      ReadData = {24'd0, count_q, ovf_q, fifo_empty, fifo_full, fsm_busy};
    end
  end

endmodule

// File: tb/tb_dmem_mmio.sv
// tb_dmem_mmio: directed bench for dmem_mmio (RAM_WORDS=256, CLKS_PER_BIT=16,
// FIFO_DEPTH=4). Bytes expected on the serial line are queued when the
// stimulus writes TXDATA; a UART receiver process decodes each frame and
// compares it with the head of the queue.
module tb_dmem_mmio;

  localparam int CPB = 16;
  localparam logic [31:0] TXDATA = 32'h1000_0000;
  localparam logic [31:0] STATUS = 32'h1000_0004;

  logic        clk;
  logic        reset;
  logic        MemWrite;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        uart_tx;
  logic        tx_busy;

  int unsigned cyc;
  int          total;
  int          bad;
  logic [7:0]  exp_q[$];
  int unsigned start_q[$];

  dmem_mmio #(
    .RAM_WORDS(256),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .MemWrite(MemWrite),
    .ALUResult(ALUResult),
    .WriteData(WriteData),
    .ReadData(ReadData),
    .uart_tx(uart_tx),
    .tx_busy(tx_busy)
  );

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic wr_now(input logic [31:0] a, input logic [31:0] d);
    MemWrite  = 1'b1;
    ALUResult = a;
    WriteData = d;
    @(posedge clk);
    #1;
    MemWrite  = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    wr_now(a, d);
  endtask

  task automatic tx_wr(input logic [7:0] b, input logic expect_sent);
    if (expect_sent) exp_q.push_back(b);
    wr(TXDATA, {24'd0, b});
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string name);
    ALUResult = a;
    #1;
    check(name, ReadData, e);
  endtask

  task automatic wait_drain(input string name);
    logic timed_out;
    timed_out = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0 && !tx_busy) begin
        timed_out = 1'b0;
        break;
      end
    end
    check(name, {31'd0, timed_out}, 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: UART receiver + scoreboard pop
  // ---------------------------------------------------------------------------
  task automatic mon_wait(input int n, inout logic ab);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (!reset) ab = 1'b1;
    end
  endtask

  initial begin
    logic       prev;
    logic       aborted;
    logic       start_bit;
    logic       stop_bit;
    logic [7:0] rx;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev = 1'b1;
      end else if (prev && !uart_tx) begin
        start_q.push_back(cyc);
        aborted = 1'b0;
        mon_wait(CPB / 2, aborted);
        start_bit = uart_tx;
        for (int i = 0; i < 8; i++) begin
          mon_wait(CPB, aborted);
          rx[i] = uart_tx;
        end
        mon_wait(CPB, aborted);
        stop_bit = uart_tx;
        if (!aborted) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL tx_unexpected: got %h expected no frame", rx);
          end else begin
            check("tx_byte", {24'd0, rx}, {24'd0, exp_q.pop_front()});
          end
          check("tx_framing", {30'd0, start_bit, stop_bit}, 32'd1);
        end
        prev = uart_tx;
      end else begin
        prev = uart_tx;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int unsigned c1;
    logic        seen_low;
    total     = 0;
    bad       = 0;
    reset     = 1'b0;
    MemWrite  = 1'b0;
    ALUResult = 32'd0;
    WriteData = 32'd0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_uart_tx", {31'd0, uart_tx}, 32'd1);
    check("rst_tx_busy", {31'd0, tx_busy}, 32'd0);
    rd(STATUS, 32'h0000_0004, "rst_status");
    @(negedge clk);
    reset = 1'b1;

    // RAM and decode
    wr(32'h0000_0010, 32'hDEAD_BEEF);
    rd(32'h0000_0013, 32'hDEAD_BEEF, "ram_unaligned_read");
    rd(32'h0000_0400, 32'h0000_0000, "ram_just_above");
    wr(32'h0000_0000, 32'h1111_1111);
    wr(32'h0000_0400, 32'hBAD0_BAD0);
    rd(32'h0000_0000, 32'h1111_1111, "unmapped_wr_no_alias");
    wr(32'h0000_03FC, 32'h1234_5678);
    rd(32'h0000_03FF, 32'h1234_5678, "ram_top_word");
    rd(TXDATA, 32'h0000_0000, "txdata_reads_zero");
    wr(32'h2000_0000, 32'hFFFF_FFFF);
    rd(32'h2000_0000, 32'h0000_0000, "unmapped_read");

    // Single frame 0x55
    tx_wr(8'h55, 1'b1);
    rd(STATUS, 32'h0000_0010, "single_status_queued");
    check("single_line_idle", {31'd0, uart_tx}, 32'd1);
    @(posedge clk);
    #1;
    check("single_start_low", {31'd0, uart_tx}, 32'd0);
    rd(STATUS, 32'h0000_0005, "single_status_sending");
    repeat (159) @(posedge clk);
    #1;
    check("single_busy_159", {31'd0, tx_busy}, 32'd1);
    @(posedge clk);
    #1;
    check("single_busy_160", {31'd0, tx_busy}, 32'd0);
    rd(STATUS, 32'h0000_0004, "single_status_done");

    // Overflow: 0x01 popped, 0x02..0x05 queued, 0x06 dropped
    for (int i = 1; i <= 6; i++) tx_wr(8'(i), (i <= 5));
    rd(STATUS, 32'h0000_004B, "ovf_status");
    wr(STATUS, 32'h0000_0007);
    rd(STATUS, 32'h0000_004B, "ovf_no_clear_bit3_low");
    wr(STATUS, 32'h0000_0008);
    rd(STATUS, 32'h0000_0043, "ovf_cleared");
    wait_drain("ovf_drain");

    // Back-to-back frames
    start_q.delete();
    tx_wr(8'hA0, 1'b1);
    tx_wr(8'h0F, 1'b1);
    wait_drain("b2b_drain");
    check("b2b_frames", start_q.size(), 32'd2);
    if (start_q.size() == 2) check("b2b_spacing", start_q[1] - start_q[0], 32'd160);

    // Full FIFO write on the same edge as the end-of-STOP pop
    tx_wr(8'h11, 1'b1);
    c1 = cyc;
    for (int i = 2; i <= 5; i++) tx_wr(8'(8'h10 + i), 1'b1);
    while (cyc != c1 + 160) @(negedge clk);
    rd(STATUS, 32'h0000_0043, "simul_before");
    exp_q.push_back(8'h16);
    wr_now(TXDATA, 32'h0000_0016);
    rd(STATUS, 32'h0000_0043, "simul_after");
    check("simul_next_start", {31'd0, uart_tx}, 32'd0);
    wait_drain("simul_drain");

    // Mid-frame reset during DATA bit 3 with two bytes queued
    tx_wr(8'h33, 1'b1);
    c1 = cyc;
    tx_wr(8'h44, 1'b1);
    tx_wr(8'h77, 1'b1);
    while (cyc != c1 + 70) @(negedge clk);
    check("midrst_line_low", {31'd0, uart_tx}, 32'd0);
    #2;
    reset = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_uart_high", {31'd0, uart_tx}, 32'd1);
    check("midrst_busy_low", {31'd0, tx_busy}, 32'd0);
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    rd(STATUS, 32'h0000_0004, "midrst_status");
    rd(32'h0000_0010, 32'hDEAD_BEEF, "midrst_ram_kept");
    seen_low = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (!uart_tx) seen_low = 1'b1;
    end
    check("midrst_no_frames", {31'd0, seen_low}, 32'd0);

    check("sb_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_mmio.md
DMEM_MMIO -- requirements
Module: dmem_mmio

Interface
REQ-001 The block SHALL have parameter RAM_WORDS, default 256, giving the data RAM depth in 32-bit words (power of two).
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 16, giving the number of clk cycles per UART bit (minimum 2).
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4, giving the TX FIFO depth in bytes (power of two, maximum 8).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port MemWrite, input, 1 bit: store strobe from the core.
REQ-007 The block SHALL have port ALUResult, input, 32 bits: byte address from the core.
REQ-008 The block SHALL have port WriteData, input, 32 bits: store data from the core.
REQ-009 The block SHALL have port ReadData, output, 32 bits: load data returned to the core.
REQ-010 The block SHALL have port uart_tx, output, 1 bit: serial line, idle high.
REQ-011 The block SHALL have port tx_busy, output, 1 bit: high while FSM not IDLE or FIFO non-empty.

Function
REQ-012 Address decode SHALL be: RAM hit when ALUResult < RAM_WORDS*4; TXDATA = 0x1000_0000; STATUS = 0x1000_0004; everything else unmapped.
- ALUResult[1:0] ignored for all regions.
- Word access only.
REQ-013 RAM reads SHALL be combinational: ReadData = mem[ALUResult[log2(RAM_WORDS)+1:2]] in the same cycle.
REQ-014 A RAM write SHALL occur on the rising clk when MemWrite=1 and RAM hit, storing all 32 bits of WriteData.
REQ-015 Reading TXDATA or an unmapped address SHALL return 0; writing an unmapped address SHALL have no effect.
REQ-016 STATUS read SHALL return {24'b0, count[3:0], ovf, empty, full, fsm_busy}, all bits combinational from current state.
REQ-017 A write to TXDATA SHALL push WriteData[7:0] into the FIFO when the FIFO is not full or a pop occurs in the same cycle.
- Otherwise the byte SHALL be dropped and ovf set (sticky).
REQ-018 A write to STATUS with WriteData[3]=1 SHALL clear ovf.
- If an overflow happens in the same cycle, set wins.
REQ-019 The TX FSM SHALL have states IDLE, START, DATA, STOP.
- uart_tx = 1 in IDLE and STOP, 0 in START, and the current data bit in DATA.
REQ-020 From IDLE with the FIFO non-empty, the FSM SHALL pop the head byte into a shift register and enter START on the next edge.
REQ-021 Each state SHALL hold for exactly CLKS_PER_BIT cycles via a bit-timer counting 0..CLKS_PER_BIT-1.
- DATA SHALL send 8 bits LSB first, using a 3-bit index.
REQ-022 At the end of STOP, the FSM SHALL pop and go directly to START if the FIFO is non-empty, else go to IDLE.
- Back-to-back frames SHALL be exactly 10*CLKS_PER_BIT cycles apart.
REQ-023 Latency: a TXDATA write at edge N into an empty FIFO with the FSM in IDLE SHALL make the FIFO non-empty after edge N, and uart_tx SHALL fall after edge N+1.
REQ-024 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count SHALL range 0..FIFO_DEPTH.
- full = (count == FIFO_DEPTH); empty = (count == 0).
- Simultaneous push and pop SHALL leave count unchanged.

Reset
REQ-025 While reset=0 the block SHALL asynchronously force:
- FSM = IDLE, uart_tx = 1, bit-timer = 0, bit index = 0;
- FIFO pointers and count = 0, ovf = 0, tx_busy = 0.
REQ-026 Reset SHALL NOT clear RAM contents.
REQ-027 A reset asserted mid-frame SHALL abort the frame, leave uart_tx high, and discard all FIFO contents.
REQ-028 The block SHALL leave reset on the first rising clk after reset=1, with no further recovery cycles.

Verification
REQ-029 RAM scenario: store 0xDEADBEEF to 0x0000_0010, then load 0x0000_0013 -> ReadData = 0xDEADBEEF; load 0x0000_0400 (RAM_WORDS=256) -> 0.
REQ-030 Single-frame scenario: write 0x55 to TXDATA with CLKS_PER_BIT=16 -> uart_tx low after the next edge, then bits 1,0,1,0,1,0,1,0 each 16 cycles, then high; tx_busy drops 160 cycles after the start bit begins.
REQ-031 Overflow scenario: 6 consecutive TXDATA writes (0x01..0x06) while FIFO_DEPTH=4 -> first byte popped, 0x02..0x05 queued, 0x06 dropped.
- STATUS reads ovf=1, full=1, count=4.
- Then write STATUS 0x8 -> ovf=0.
REQ-032 Back-to-back scenario: queue 0xA0, 0x0F -> the second start bit begins exactly 160 cycles after the first; no idle gap.
REQ-033 Mid-frame reset scenario: reset=0 during DATA bit 3 with 2 bytes queued -> uart_tx=1 immediately, STATUS = 0x4 after release, no further frames.
- RAM word previously written still reads back.
REQ-034 Simultaneous scenario: with FIFO full, a TXDATA write on the same edge as an end-of-STOP pop -> byte accepted, count stays 4, ovf stays 0.
